regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameters: DW, 32, data width; AW, 5, register-address width.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 a_valid  input  1  requester A (pipeline write-back) has a write.
REQ-005 a_ready  output  1  A's write is accepted this cycle.
REQ-006 a_reg  input  AW  A destination register; a_data  input  DW  A write data.
REQ-007 b_valid  input  1  requester B (multi-cycle unit write-back) has a write.
REQ-008 b_ready  output  1  B's write is accepted this cycle.
REQ-009 b_reg  input  AW  B destination register; b_data  input  DW  B write data.
REQ-010 flush  input  1  synchronous discard of all buffered writes.
REQ-011 RegWrite  output  1  write strobe to the register file.
REQ-012 Write_register  output  AW  and Write_data  output  DW: register-file write address and data.
REQ-013 Read_register1, Read_register2  input  AW  register-file read addresses for hazard check.
REQ-014 pend1, pend2  output  1  the matching read address has a buffered, uncommitted write.

Function
REQ-015 Per requester: one-entry slot (full bit, reg, data); a write is accepted on the edge where valid && ready.
REQ-016 ready = !flush && (!slot_full || slot granted this cycle); accept into a draining slot reloads it on the same edge.
REQ-017 Grant, combinational: only one slot full -> that slot; both full -> round-robin away from last_grant, except REQ-018.
REQ-018 Both full, same nonzero reg -> grant the older slot (age bit set at load); loaded same edge -> A first.
REQ-019 Granted slot drives Write_register/Write_data; RegWrite = granted && reg != 0 && !flush.
REQ-020 Granted slot clears on the edge unless reloaded; last_grant updates only when a grant occurs.
REQ-021 Grant to reg 0 consumes the slot with RegWrite low (write dropped).
REQ-022 Latency: accepted at edge N -> RegWrite high in cycle after N -> committed at edge N+1 if uncontended; worst case edge N+2.
REQ-023 At most one write per cycle; no write ever lost except via reg 0 or flush.
REQ-024 pendX = ReadX != 0 && matches reg of any full slot; ignores inputs not yet accepted.
REQ-025 flush high: RegWrite low, ready low, both slots and age bits clear on the edge; last_grant unchanged.
REQ-026 Data width is passed through unmodified; no arithmetic on data.

Reset
REQ-027 reset low, asynchronously: slots empty, age bits clear, last_grant = B (A wins first tie).
REQ-028 During reset: RegWrite 0, Write_register 0, Write_data 0, pend1/pend2 0, a_ready/b_ready 0.
REQ-029 Reset mid-operation discards buffered writes; after release ready rises in the first cycle.

Verification
REQ-030 A only: a_reg=5, a_data=0x1234 at edge 1 -> RegWrite=1, Write_register=5, Write_data=0x1234 in cycle 2, committed edge 2.
REQ-031 A and B valid every cycle, regs 3/4 -> grants alternate A,B,A,B; one commit per cycle; a_ready/b_ready alternate.
REQ-032 B loads reg 7=0xB at edge 1, A loads reg 7=0xA at edge 2 (B not yet granted) -> B commits first, then A; final reg 7 = 0xA.
REQ-033 a_reg=0, a_data=0xFFFF -> slot consumed, RegWrite stays 0, a_ready back high next cycle.
REQ-034 Slot A holds reg 9, Read_register1=9 -> pend1=1; Read_register2=0 -> pend2=0; after commit pend1=0.
REQ-035 flush with both slots full -> no RegWrite that cycle, slots empty after edge; reset low mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter: one buffered write slot per requester,
// round-robin grant with same-register ordering by age, and read-hazard pending flags.
module regfile_write_arbiter #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_reg,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_reg,
  input  logic [DW-1:0] b_data,
  input  logic          flush,
  output logic          RegWrite,
  output logic [AW-1:0] Write_register,
  output logic [DW-1:0] Write_data,
  input  logic [AW-1:0] Read_register1,
  input  logic [AW-1:0] Read_register2,
  output logic          pend1,
  output logic          pend2
);

  logic          a_full_q, a_full_d;
  logic [AW-1:0] a_reg_q,  a_reg_d;
  logic [DW-1:0] a_data_q, a_data_d;
  logic          age_a_q,  age_a_d;
  logic          b_full_q, b_full_d;
  logic [AW-1:0] b_reg_q,  b_reg_d;
  logic [DW-1:0] b_data_q, b_data_d;
  logic          age_b_q,  age_b_d;
  logic          last_b_q, last_b_d;

  logic gnt_a, gnt_b, a_load, b_load, same_reg;

  assign same_reg = (a_reg_q == b_reg_q) && (a_reg_q != '0);

  // Grant: lone full slot wins; on a same-register conflict the older slot wins,
  // otherwise alternate away from the previous winner.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!flush) begin
      if (a_full_q && !b_full_q) begin
        gnt_a = 1'b1;
      end else if (b_full_q && !a_full_q) begin
        gnt_b = 1'b1;
      end else if (a_full_q && b_full_q) begin
        if (same_reg) begin
          if (age_b_q) gnt_b = 1'b1;
          else         gnt_a = 1'b1;
        end else if (last_b_q) begin
          gnt_a = 1'b1;
        end else begin
          gnt_b = 1'b1;
        end
      end
    end
  end

  assign a_ready = reset && !flush && (!a_full_q || gnt_a);
  assign b_ready = reset && !flush && (!b_full_q || gnt_b);
  assign a_load  = a_valid && a_ready;
  assign b_load  = b_valid && b_ready;

  always_comb begin
    Write_register = '0;
    Write_data     = '0;
    if (gnt_a) begin
      Write_register = a_reg_q;
      Write_data     = a_data_q;
    end else if (gnt_b) begin
      Write_register = b_reg_q;
      Write_data     = b_data_q;
    end
  end

  // Register 0 grants still consume the slot but never strobe the file.
  assign RegWrite = (gnt_a || gnt_b) && (Write_register != '0);

  assign pend1 = (Read_register1 != '0) &&
                 ((a_full_q && (a_reg_q == Read_register1)) ||
                  (b_full_q && (b_reg_q == Read_register1)));
  assign pend2 = (Read_register2 != '0) &&
                 ((a_full_q && (a_reg_q == Read_register2)) ||
                  (b_full_q && (b_reg_q == Read_register2)));

  // Next-state: slot occupancy, payload, age ordering and round-robin pointer.
  always_comb begin
    a_full_d = a_full_q;
    a_reg_d  = a_reg_q;
    a_data_d = a_data_q;
    b_full_d = b_full_q;
    b_reg_d  = b_reg_q;
    b_data_d = b_data_q;
    age_a_d  = age_a_q;
    age_b_d  = age_b_q;
    last_b_d = last_b_q;
    if (flush) begin
      a_full_d = 1'b0;
      b_full_d = 1'b0;
      age_a_d  = 1'b0;
      age_b_d  = 1'b0;
    end else begin
      if (gnt_a) begin
        a_full_d = 1'b0;
        last_b_d = 1'b0;
      end
      if (gnt_b) begin
        b_full_d = 1'b0;
        last_b_d = 1'b1;
      end
      if (a_load) begin
        a_full_d = 1'b1;
        a_reg_d  = a_reg;
        a_data_d = a_data;
      end
      if (b_load) begin
        b_full_d = 1'b1;
        b_reg_d  = b_reg;
        b_data_d = b_data;
      end
      // A slot loaded while the other stays occupied is the younger one.
      if (a_load && b_load) begin
        age_a_d = 1'b1;
        age_b_d = 1'b0;
      end else if (a_load) begin
        age_a_d = 1'b0;
        age_b_d = b_full_d;
      end else if (b_load) begin
        age_b_d = 1'b0;
        age_a_d = a_full_d;
      end else begin
        age_a_d = age_a_q && a_full_d;
        age_b_d = age_b_q && b_full_d;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_full_q <= 1'b0;
      a_reg_q  <= '0;
      a_data_q <= '0;
      age_a_q  <= 1'b0;
      b_full_q <= 1'b0;
      b_reg_q  <= '0;
      b_data_q <= '0;
      age_b_q  <= 1'b0;
      last_b_q <= 1'b1;
    end else begin
      a_full_q <= a_full_d;
      a_reg_q  <= a_reg_d;
      a_data_q <= a_data_d;
      age_a_q  <= age_a_d;
      b_full_q <= b_full_d;
      b_reg_q  <= b_reg_d;
      b_data_q <= b_data_d;
      age_b_q  <= age_b_d;
      last_b_q <= last_b_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized scoreboard bench for regfile_write_arbiter: a timestamp-based reference
// model predicts per-cycle handshake/hazard status and the ordered commit stream.
module tb_regfile_write_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, a_valid, a_ready, b_valid, b_ready, flush;
  logic [AW-1:0] a_reg, b_reg, Write_register, Read_register1, Read_register2;
  logic [DW-1:0] a_data, b_data, Write_data;
  logic          RegWrite, pend1, pend2;

  regfile_write_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .flush(flush), .RegWrite(RegWrite), .Write_register(Write_register),
    .Write_data(Write_data), .Read_register1(Read_register1),
    .Read_register2(Read_register2), .pend1(pend1), .pend2(pend2)
  );

  typedef struct { bit ar; bit br; bit p1; bit p2; bit we; bit in_rst; } status_t;
  typedef struct { logic [AW-1:0] r; logic [DW-1:0] d; } commit_t;

  status_t st_q[$];
  commit_t cm_q[$];
  int      checks = 0;
  int      errors = 0;
  bit      mon_en = 1'b0;

  // Reference model: pending writes per requester, stamped with their load cycle.
  bit            m_full[2];
  logic [AW-1:0] m_reg[2];
  logic [DW-1:0] m_data[2];
  int            m_stamp[2];
  int            m_last;
  int            cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hazard(input logic [AW-1:0] r);
    return (r != '0) && ((m_full[0] && m_reg[0] == r) || (m_full[1] && m_reg[1] == r));
  endfunction

  // Called at posedge+1; drives one cycle of inputs, records expectations, steps the model.
  task automatic drive_cycle(input bit rst_low, input bit fl,
                             input bit av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                             input bit bv, input logic [AW-1:0] br, input logic [DW-1:0] bd,
                             input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    bit gv, gi;
    bit rdy[2];
    status_t s;
    commit_t c;
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    flush = fl; Read_register1 = r1; Read_register2 = r2;
    if (rst_low) begin
      reset = 1'b0;
      m_full[0] = 1'b0; m_full[1] = 1'b0; m_last = 1;
      #1;
      chk("rst_async_regwrite", 64'(RegWrite), 64'(0));
      chk("rst_async_readys", 64'({a_ready, b_ready}), 64'(0));
      chk("rst_async_pends", 64'({pend1, pend2}), 64'(0));
    end else begin
      reset = 1'b1;
    end
    gv = 1'b0; gi = 1'b0;
    if (!rst_low && !fl) begin
      if (m_full[0] && m_full[1]) begin
        gv = 1'b1;
        if (m_reg[0] == m_reg[1] && m_reg[0] != '0) gi = (m_stamp[1] < m_stamp[0]);
        else                                        gi = (m_last == 1) ? 1'b0 : 1'b1;
      end else if (m_full[0]) begin
        gv = 1'b1; gi = 1'b0;
      end else if (m_full[1]) begin
        gv = 1'b1; gi = 1'b1;
      end
    end
    for (int x = 0; x < 2; x++)
      rdy[x] = !rst_low && !fl && (!m_full[x] || (gv && gi == x[0]));
    s.ar = rdy[0]; s.br = rdy[1];
    s.p1 = hazard(r1); s.p2 = hazard(r2);
    s.we = gv && (m_reg[gi] != '0);
    s.in_rst = rst_low;
    if (s.we) begin
      c.r = m_reg[gi]; c.d = m_data[gi];
      cm_q.push_back(c);
    end
    st_q.push_back(s);
    @(posedge clk);
    cyc++;
    if (!rst_low) begin
      if (fl) begin
        m_full[0] = 1'b0; m_full[1] = 1'b0;
      end else begin
        if (gv) begin m_full[gi] = 1'b0; m_last = int'(gi); end
        if (av && rdy[0]) begin m_full[0] = 1'b1; m_reg[0] = ar; m_data[0] = ad; m_stamp[0] = cyc; end
        if (bv && rdy[1]) begin m_full[1] = 1'b1; m_reg[1] = br; m_data[1] = bd; m_stamp[1] = cyc; end
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input logic [AW-1:0] r1);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, '0, '0, 0, '0, '0, r1, '0);
  endtask

  // Monitor: mid-cycle status against the per-cycle queue, strobes against the commit queue.
  status_t ms;
  commit_t mc;
  always @(negedge clk) begin
    if (mon_en) begin
      if (st_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL status_underflow got empty want entry at %0t", $time);
      end else begin
        ms = st_q.pop_front();
        chk("a_ready", 64'(a_ready), 64'(ms.ar));
        chk("b_ready", 64'(b_ready), 64'(ms.br));
        chk("pend1", 64'(pend1), 64'(ms.p1));
        chk("pend2", 64'(pend2), 64'(ms.p2));
        chk("RegWrite", 64'(RegWrite), 64'(ms.we));
        if (ms.in_rst) begin
          chk("rst_write_register", 64'(Write_register), 64'(0));
          chk("rst_write_data", 64'(Write_data), 64'(0));
        end
      end
      if (RegWrite === 1'b1) begin
        if (cm_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_commit got reg %0d want none at %0t", Write_register, $time);
        end else begin
          mc = cm_q.pop_front();
          chk("Write_register", 64'(Write_register), 64'(mc.r));
          chk("Write_data", 64'(Write_data), 64'(mc.d));
        end
      end
    end
  end

  int rst_cnt;

  initial begin
    reset = 1'b0; flush = 1'b0;
    a_valid = 1'b0; a_reg = '0; a_data = '0;
    b_valid = 1'b0; b_reg = '0; b_data = '0;
    Read_register1 = '0; Read_register2 = '0;
    m_full[0] = 1'b0; m_full[1] = 1'b0; m_last = 1;
    m_reg[0] = '0; m_reg[1] = '0; m_data[0] = '0; m_data[1] = '0;
    m_stamp[0] = 0; m_stamp[1] = 0;
    #1;
    chk("reset_outputs", 64'({RegWrite, a_ready, b_ready, pend1, pend2}), 64'(0));
    chk("reset_write_bus", 64'({Write_register, Write_data}), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    drive_cycle(1, 0, 1, AW'(5), DW'(32'h55), 1, AW'(6), DW'(32'h66), '0, '0);

    // Lone A write: commits the cycle after acceptance.
    drive_cycle(0, 0, 1, AW'(5), DW'(32'h1234), 0, '0, '0, '0, '0);
    idle(2, '0);
    // Both requesters streaming to distinct registers: grants alternate.
    for (int i = 0; i < 6; i++)
      drive_cycle(0, 0, 1, AW'(3), DW'($urandom), 1, AW'(4), DW'($urandom), AW'(3), AW'(4));
    idle(3, '0);
    // Same-register ordering: older B value lands before younger A value.
    drive_cycle(0, 0, 1, AW'(1), DW'(32'h1), 1, AW'(7), DW'(32'hB), AW'(7), '0);
    drive_cycle(0, 0, 1, AW'(7), DW'(32'hA), 0, '0, '0, AW'(7), '0);
    idle(3, AW'(7));
    // Register 0 write is consumed silently.
    drive_cycle(0, 0, 1, AW'(0), DW'(32'hFFFF), 0, '0, '0, '0, '0);
    idle(2, '0);
    // Hazard flag tracks the buffered write until it commits.
    drive_cycle(0, 0, 1, AW'(9), DW'(32'h99), 0, '0, '0, AW'(9), '0);
    idle(3, AW'(9));
    // Flush with both slots occupied discards them.
    drive_cycle(0, 0, 1, AW'(10), DW'(32'hA0), 1, AW'(11), DW'(32'hB0), AW'(10), AW'(11));
    drive_cycle(0, 1, 1, AW'(12), DW'(32'hC0), 1, AW'(13), DW'(32'hD0), AW'(10), AW'(11));
    idle(2, AW'(10));

    rst_cnt = 0;
    for (int i = 0; i < 500; i++) begin
      if (rst_cnt == 0 && $urandom_range(0, 99) == 0) rst_cnt = 2;
      drive_cycle(rst_cnt != 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 6, AW'($urandom_range(0, 7)), DW'($urandom),
                  $urandom_range(0, 9) < 6, AW'($urandom_range(0, 7)), DW'($urandom),
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      if (rst_cnt != 0) rst_cnt--;
    end
    idle(4, '0);
    mon_en = 1'b0;
    chk("commit_queue_drained", 64'(cm_q.size()), 64'(0));
    chk("status_queue_drained", 64'(st_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
